// File: rtl/dcache_pkg.sv
// Shared CPU types for the data cache.
// Contents:
//   word_t          32-bit machine word
//   DCACHE_*        default geometry and the tag/index widths derived from it
//   dcache_frame_t  one cache frame: valid, dirty, tag, data
//   dcache_state_t  controller states
package dcache_pkg;

  typedef logic [31:0] word_t;

  localparam int DCACHE_FRAMES = 8;
  localparam int DCACHE_IDX_W  = 3;
  // One word per frame: tag is whatever remains above index and byte offset.
  localparam int DCACHE_TAG_W  = 32 - DCACHE_IDX_W - 2;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [DCACHE_TAG_W-1:0] tag;
    word_t                   data;
  } dcache_frame_t;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH,
    DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_frames.sv
// Frame storage for the direct-mapped data cache.
// One combinational read port and one write port sharing the same index
// (the controller only ever writes the frame it is currently looking at).
// Ports:
//   CLK, nRST           clock, asynchronous active-low reset
//   rd_idx              frame being looked at
//   rd_valid..rd_data   contents of that frame
//   wr_en               write the frame at rd_idx with wr_valid..wr_data
// Only valid/dirty are reset; tag/data are plain storage qualified by valid.
module dcache_frames
  import dcache_pkg::*;
#(
  parameter int FRAMES = DCACHE_FRAMES,
  parameter int IDX_W  = DCACHE_IDX_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [29-IDX_W:0] rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [29-IDX_W:0] wr_tag,
  input  logic [31:0]       wr_data
);

  localparam int TAG_W = 30 - IDX_W;

  logic [FRAMES-1:0] valid_reg;
  logic [FRAMES-1:0] dirty_reg;
  logic [TAG_W-1:0]  tag_mem  [FRAMES];
  word_t             data_mem [FRAMES];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (wr_en) begin
      valid_reg[rd_idx] <= wr_valid;
      dirty_reg[rd_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_mem[rd_idx]  <= wr_tag;
      data_mem[rd_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_dirty = dirty_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache, one word per frame.
// Serves pipeline loads/stores, fills and evicts over a request/wait memory
// handshake, and on halt writes back every dirty frame before raising flushed.
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   halt                      pipeline halt (sticky)
//   dmemREN/dmemWEN           pipeline load/store request (both high = store)
//   dmemaddr/dmemstore        request byte address / store data
//   dhit/dmemload             request satisfied this cycle / load data
//   flushed                   halt write-back complete
//   dREN/dWEN/daddr/dstore    memory request, word address, write data
//   dwait/dload               memory busy / memory read data
module dcache
  import dcache_pkg::*;
#(
  parameter int FRAMES = DCACHE_FRAMES,
  parameter int IDX_W  = DCACHE_IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int TAG_W = 30 - IDX_W;

  dcache_state_t    state_reg, state_next;
  logic [IDX_W-1:0] flush_idx_reg, flush_idx_next;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             req;
  logic             hit;
  logic             last_idx;
  logic             flush_step;
  logic             unused_addr_bits;

  logic             rd_valid, rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  dcache_frame_t    cur;
  dcache_frame_t    upd;
  logic             wr_en;

  assign req_tag = dmemaddr[31:IDX_W+2];
  assign req_idx = dmemaddr[IDX_W+1:2];
  // Byte offset is irrelevant for word-sized frames.
  assign unused_addr_bits = ^dmemaddr[1:0];

  // During the flush sweep the frame under the sweep counter is examined;
  // otherwise the frame selected by the pipeline address.
  assign rd_idx   = (state_reg == FLUSH) ? flush_idx_reg : req_idx;
  assign cur      = {rd_valid, rd_dirty, rd_tag, rd_data};
  assign req      = dmemREN | dmemWEN;
  assign hit      = cur.valid && (cur.tag == req_tag);
  assign last_idx = (flush_idx_reg == IDX_W'(FRAMES - 1));

  dcache_frames #(
    .FRAMES (FRAMES),
    .IDX_W  (IDX_W)
  ) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_valid (upd.valid),
    .wr_dirty (upd.dirty),
    .wr_tag   (upd.tag),
    .wr_data  (upd.data)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= IDLE;
      flush_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_idx_reg <= flush_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_idx_next = flush_idx_reg;
    dhit           = 1'b0;
    dmemload       = '0;
    flushed        = 1'b0;
    dREN           = 1'b0;
    dWEN           = 1'b0;
    daddr          = '0;
    dstore         = '0;
    wr_en          = 1'b0;
    upd            = cur;
    flush_step     = 1'b0;

    case (state_reg)
      IDLE: begin
        // halt wins over a pending request; a request left standing is dropped.
        if (halt) begin
          state_next     = FLUSH;
          flush_idx_next = '0;
        end else if (req) begin
          if (hit) begin
            dhit     = 1'b1;
            dmemload = cur.data;
            if (dmemWEN) begin
              wr_en     = 1'b1;
              upd.data  = dmemstore;
              upd.dirty = 1'b1;
            end
          end else if (cur.valid && cur.dirty) begin
            state_next = WB;
          end else begin
            state_next = FETCH;
          end
        end
      end

      WB: begin
        dWEN   = 1'b1;
        daddr  = {cur.tag, req_idx, 2'b00};
        dstore = cur.data;
        if (!dwait) begin
          wr_en      = 1'b1;
          upd.dirty  = 1'b0;
          state_next = FETCH;
        end
      end

      FETCH: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) begin
          wr_en      = 1'b1;
          upd.valid  = 1'b1;
          upd.dirty  = 1'b0;
          upd.tag    = req_tag;
          upd.data   = dload;
          // Back to IDLE: the held request then completes as a hit.
          state_next = IDLE;
        end
      end

      FLUSH: begin
        if (cur.valid && cur.dirty) begin
          dWEN   = 1'b1;
          daddr  = {cur.tag, flush_idx_reg, 2'b00};
          dstore = cur.data;
          if (!dwait) begin
            wr_en      = 1'b1;
            upd.dirty  = 1'b0;
            flush_step = 1'b1;
          end
        end else begin
          flush_step = 1'b1;
        end
        // The counter stops at the last frame rather than wrapping.
        if (flush_step) begin
          if (last_idx) begin
            state_next = DONE;
          end else begin
            flush_idx_next = flush_idx_reg + 1'b1;
          end
        end
      end

      DONE: begin
        flushed = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
`timescale 1ns/1ps
module tb_dcache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait = 1'b0;
  logic [31:0] dload = '0;

  dcache dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .halt      (halt),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .flushed   (flushed),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- backing memory and golden (pipeline-visible) memory
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] gmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction
  function automatic logic [31:0] bread(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] gread(input logic [31:0] a);
    return gmem.exists(a) ? gmem[a] : init_word(a);
  endfunction

  // ---------------- cache content model (what a direct-mapped WB cache holds)
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [26:0] m_tag   [8];
  logic [31:0] m_data  [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  // ---------------- memory responder
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
    int unsigned ncyc;
  } xfer_t;
  xfer_t xlog[$];

  bit          fixed_mode = 1;
  int unsigned wait_cfg = 0;
  bit          in_xfer = 0;
  int unsigned remain = 0;

  always @(posedge CLK) begin
    #2;
    if (!nRST) begin
      in_xfer = 0;
      dwait   = 0;
      dload   = $urandom;
    end else if (dREN || dWEN) begin
      if (!in_xfer) begin
        in_xfer = 1;
        remain  = fixed_mode ? wait_cfg : $urandom_range(0, 3);
      end
      if (remain != 0) begin
        dwait = 1;
        remain--;
      end else begin
        dwait   = 0;
        in_xfer = 0;
      end
      dload = dREN ? bread(daddr) : $urandom;
    end else begin
      dwait = 1'($urandom_range(0, 1));
      dload = $urandom;
    end
  end

  // ---------------- per-cycle compare process
  int unsigned mon_cnt = 0;
  bit          seen_flushed = 0;

  always @(negedge CLK) begin
    if (!nRST) begin
      mon_cnt      = 0;
      seen_flushed = 0;
    end else begin
      chk("rw_exclusive", 32'(dREN & dWEN), 32'd0);
      if (!dREN && !dWEN) begin
        chk("idle_daddr", daddr, 32'd0);
        chk("idle_dstore", dstore, 32'd0);
      end else begin
        chk("daddr_align", 32'(daddr[1:0]), 32'd0);
      end
      if (dREN) chk("fetch_addr", daddr, {dmemaddr[31:2], 2'b00});
      if (halt) chk("halt_no_hit", 32'(dhit), 32'd0);
      if (flushed) chk("flushed_quiet", 32'({dREN, dWEN, dhit}), 32'd0);
      if (seen_flushed) chk("flushed_sticky", 32'(flushed), 32'd1);
      if (flushed) seen_flushed = 1;
      if (dREN || dWEN) begin
        mon_cnt++;
        if (!dwait) begin
          if (fixed_mode) chk("xfer_cycles", mon_cnt, wait_cfg + 1);
          xlog.push_back('{dWEN, daddr, (dWEN ? dstore : dload), cyc, mon_cnt});
          if (dWEN) bmem[daddr] = dstore;
          mon_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver
  int          nreq = 0;
  logic [31:0] last_load;

  task automatic idle_cycle();
    @(posedge CLK);
    #1;
    dmemREN = 0;
    dmemWEN = 0;
  endtask

  task automatic do_req(input bit we, input bit both, input logic [31:0] addr,
                        input logic [31:0] sdata);
    logic [31:0] wa;
    logic [2:0]  idx;
    logic [26:0] tg;
    bit          hit;
    bit          got;
    xfer_t       exp_q[$];
    int          base;
    int unsigned start_cyc;
    int unsigned hit_cyc;
    wa  = {addr[31:2], 2'b00};
    idx = wa[4:2];
    tg  = wa[31:5];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    got = 0;
    hit_cyc = 0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx])
        exp_q.push_back('{1'b1, {m_tag[idx], idx, 2'b00}, m_data[idx], 0, 0});
      exp_q.push_back('{1'b0, wa, 32'd0, 0, 0});
    end

    @(posedge CLK);
    #1;
    dmemaddr  = addr;
    dmemstore = sdata;
    dmemWEN   = we;
    dmemREN   = !we || both;
    start_cyc = cyc;
    base      = xlog.size();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (dhit) begin
        got     = 1;
        hit_cyc = cyc;
        break;
      end
    end
    chk("dhit_timeout", 32'(got), 32'd1);
    last_load = dmemload;
    if (got) begin
      chk("xfer_count", 32'(xlog.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && base + i < xlog.size(); i++) begin
        chk("xfer_dir", 32'(xlog[base+i].we), 32'(exp_q[i].we));
        chk("xfer_addr", xlog[base+i].addr, exp_q[i].addr);
        if (exp_q[i].we) chk("xfer_wdata", xlog[base+i].data, exp_q[i].data);
      end
      if (hit) chk("hit_latency", hit_cyc - start_cyc, 32'd0);
      else if (xlog.size() > base) chk("miss_latency", hit_cyc, xlog[$].cyc + 1);
      if (!we) chk("load_data", dmemload, gread(wa));
    end
    if (!hit) begin
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      m_data[idx]  = gread(wa);
    end
    if (we) begin
      m_data[idx]  = sdata;
      m_dirty[idx] = 1;
      gmem[wa]     = sdata;
    end
    nreq++;
    $display("REQ %0d %s addr=%h data=%h %s xfers=%0d load=%h", nreq,
             we ? "ST" : "LD", addr, sdata, hit ? "hit " : "miss",
             xlog.size() - base, dmemload);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    bit          got;
    logic [26:0] tg;
    logic [2:0]  ix;
    logic [31:0] addr;
    xfer_t       exp_f[$];

    model_clear();

    // reset state
    #12;
    chk("rst_dhit", 32'(dhit), 32'd0);
    chk("rst_dREN", 32'(dREN), 32'd0);
    chk("rst_dWEN", 32'(dWEN), 32'd0);
    chk("rst_flushed", 32'(flushed), 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1;

    // cold load with dwait high for 2 cycles
    fixed_mode = 1;
    wait_cfg   = 2;
    n0 = xlog.size();
    do_req(0, 0, 32'h40, 32'h0);
    chk("lit_cold_load", last_load, 32'hC0DE0040);
    chk("lit_cold_xfers", 32'(xlog.size() - n0), 32'd1);
    if (xlog.size() > n0) begin
      chk("lit_cold_addr", xlog[n0].addr, 32'h40);
      chk("lit_cold_dren_cycles", xlog[n0].ncyc, 32'd3);
    end

    // store hit, then load back
    n0 = xlog.size();
    do_req(1, 0, 32'h40, 32'hDEADBEEF);
    chk("lit_store_hit_no_traffic", 32'(xlog.size() - n0), 32'd0);
    do_req(0, 0, 32'h40, 32'h0);
    chk("lit_load_after_store", last_load, 32'hDEADBEEF);

    // conflicting load on dirty frame 0: write-back then fetch
    wait_cfg = 1;
    n0 = xlog.size();
    do_req(0, 0, 32'h60, 32'h0);
    chk("lit_wb_xfers", 32'(xlog.size() - n0), 32'd2);
    if (xlog.size() >= n0 + 2) begin
      chk("lit_wb_dir", 32'(xlog[n0].we), 32'd1);
      chk("lit_wb_addr", xlog[n0].addr, 32'h40);
      chk("lit_wb_data", xlog[n0].data, 32'hDEADBEEF);
      chk("lit_refill_addr", xlog[n0+1].addr, 32'h60);
    end
    chk("lit_wb_load", last_load, 32'hC0DE0060);

    // store miss on clean frame 1
    n0 = xlog.size();
    do_req(1, 0, 32'h84, 32'h12345678);
    chk("lit_stmiss_xfers", 32'(xlog.size() - n0), 32'd1);
    chk("lit_model_frame1_dirty", 32'(m_dirty[1]), 32'd1);
    chk("lit_model_frame1_data", m_data[1], 32'h12345678);
    do_req(0, 0, 32'h84, 32'h0);
    chk("lit_stmiss_readback", last_load, 32'h12345678);

    // reset in the middle of a fetch
    wait_cfg = 6;
    @(posedge CLK);
    #1;
    dmemaddr = 32'hA8;
    dmemREN  = 1;
    dmemWEN  = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (dREN) begin
        got = 1;
        break;
      end
    end
    chk("rstfetch_dREN_seen", 32'(got), 32'd1);
    @(posedge CLK);
    #3;
    nRST    = 0;
    dmemREN = 0;
    #1;
    chk("rstfetch_dREN_drop", 32'(dREN), 32'd0);
    chk("rstfetch_dWEN", 32'(dWEN), 32'd0);
    chk("rstfetch_daddr", daddr, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1;
    model_clear();
    gmem = bmem;
    wait_cfg = 0;
    n0 = xlog.size();
    do_req(0, 0, 32'h84, 32'h0);
    chk("lit_post_reset_miss", 32'(xlog.size() - n0), 32'd1);
    chk("lit_post_reset_data", last_load, 32'hC0DE0084);

    // randomized traffic
    fixed_mode = 0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: tg = 27'd0;
        1: tg = 27'd1;
        2: tg = 27'd2;
        3: tg = 27'd3;
        default: tg = 27'h4000001;
      endcase
      ix   = 3'($urandom_range(0, 7));
      addr = {tg, ix, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        do_req(1, ($urandom_range(0, 3) == 0), addr, $urandom);
      else
        do_req(0, 0, addr, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    // halt with frames 0 and 3 dirty, raised during a load-miss fetch
    @(negedge CLK);
    nRST = 0;
    repeat (2) @(negedge CLK);
    nRST = 1;
    model_clear();
    gmem = bmem;
    do_req(1, 0, 32'h40, 32'hA1A1A1A1);
    do_req(1, 0, 32'h0C, 32'hB2B2B2B2);
    do_req(0, 0, 32'h48, 32'h0);
    n0 = xlog.size();
    @(posedge CLK);
    #1;
    dmemaddr = 32'h14;
    dmemREN  = 1;
    dmemWEN  = 0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (dREN) begin
        got = 1;
        break;
      end
    end
    chk("halt_fetch_seen", 32'(got), 32'd1);
    halt = 1;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (flushed) begin
        got = 1;
        break;
      end
    end
    chk("flush_timeout", 32'(got), 32'd1);
    m_valid[5] = 1;
    m_dirty[5] = 0;
    m_tag[5]   = 27'd0;
    m_data[5]  = gread(32'h14);
    exp_f.push_back('{1'b0, 32'h14, 32'd0, 0, 0});
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_dirty[i])
        exp_f.push_back('{1'b1, {m_tag[i], 3'(i), 2'b00}, m_data[i], 0, 0});
      m_dirty[i] = 0;
    end
    chk("flush_xfer_count", 32'(xlog.size() - n0), 32'(exp_f.size()));
    for (int i = 0; i < exp_f.size() && n0 + i < xlog.size(); i++) begin
      chk("flush_dir", 32'(xlog[n0+i].we), 32'(exp_f[i].we));
      chk("flush_addr", xlog[n0+i].addr, exp_f[i].addr);
      if (exp_f[i].we) chk("flush_data", xlog[n0+i].data, exp_f[i].data);
    end
    chk("lit_flush_xfers", 32'(xlog.size() - n0), 32'd3);
    if (xlog.size() >= n0 + 3) begin
      chk("lit_flush_first_addr", xlog[n0+1].addr, 32'h40);
      chk("lit_flush_first_data", xlog[n0+1].data, 32'hA1A1A1A1);
      chk("lit_flush_second_addr", xlog[n0+2].addr, 32'h0C);
      chk("lit_flush_second_data", xlog[n0+2].data, 32'hB2B2B2B2);
    end
    repeat (10) @(negedge CLK);
    chk("lit_flushed_held", 32'(flushed), 32'd1);
    chk("done_no_xfers", 32'(xlog.size() - n0), 32'(exp_f.size()));

    foreach (gmem[k]) chk("final_mem", bread(k), gmem[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
